hazard_unit_sb: RTL and testbench
=================================

// Module: hazard_unit_sb
// PURPOSE
//  Second-generation RV32 pipeline hazard controller (F/D/E/M/W).
//  - Resolves RAW hazards by forwarding, with a no-forward mode selected by parameter.
//  - Inserts load-use bubbles and freezes the whole pipe on data-memory wait states.
//  - Tracks pending writes from a multi-cycle MUL/DIV unit (MDU) with a register scoreboard.
//  - Performs branch flushes and keeps saturating stall and flush counters.
// PARAMETERS
//  FWD_EN      1   1: M->E and W->E forwarding; 0: forwards forced 00, any RAW on rd_e/rd_m/rd_w stalls D
//  NUM_REGS    32  architectural registers (x0 hard-wired zero)
//  RA_W        5   register address width, equal to clog2(NUM_REGS)
//  MDU_DEPTH   2   max outstanding MDU ops (1..NUM_REGS-1)
//  CNT_W       32  perf counter width
// PORTS
//  clk             in   1     rising-edge clock
//  rst_n           in   1     async active-low reset
//  rs1_d,rs2_d,rd_d in  RA_W  D-stage source and destination registers
//  reg_write_d     in   1     D instruction writes rd_d
//  mdu_op_d        in   1     D instruction is an MDU op
//  rs1_e,rs2_e,rd_e in  RA_W  E-stage registers
//  is_load_e       in   1     E instruction is a load
//  pc_src_e        in   1     taken branch/jump resolved in E
//  mdu_issue_e     in   1     MDU op leaves E this cycle; writes rd_e later
//  rd_m,rd_w       in   RA_W  M and W destination registers
//  reg_write_m/_w  in   1     M/W write enables
//  mem_req_m       in   1     M-stage load/store active
//  mem_ready       in   1     data memory ack
//  mdu_done        in   1     MDU result written to RF this cycle
//  mdu_done_rd     in   RA_W  register written by that result
//  cnt_clr         in   1     synchronous clear of perf counters
//  forward_a_e/_b_e out 2     00 RF, 01 W, 10 M
//  stall_pc,stall_f,stall_d,stall_e,stall_m out 1  hold stage registers
//  flush_d,flush_e out  1     insert bubble into D / E register
//  sb_busy         out  NUM_REGS  scoreboard vector (bit0 always 0)
//  stall_cnt,flush_cnt out CNT_W  perf counters
// BEHAVIOUR
//  Reset: sb_busy=0, outstanding=0, counters=0; all outputs are then driven combinationally from inputs.
//  Forwarding (FWD_EN=1):
//   - 10 if rsX_e==rd_m, reg_write_m, and rsX_e!=0.
//   - Otherwise 01 for the same test on W.
//   - Otherwise 00. M has priority over W.
//  Hazard terms, all requiring rs!=0:
//   - freeze: mem_req_m & !mem_ready.
//   - lu: is_load_e & rd_e!=0 & (rs1_d==rd_e | rs2_d==rd_e).
//   - raw0 (FWD_EN=0 only): rsX_d matches rd_e, rd_m or rd_w with the matching write enable.
//   - sbh: sb_busy[rs1_d] | sb_busy[rs2_d] | (reg_write_d & sb_busy[rd_d]) (WAW).
//   - st: mdu_op_d & (outstanding + mdu_issue_e) >= MDU_DEPTH.
//  Priority is freeze > pc_src_e > (lu|raw0|sbh|st):
//   - freeze: stall_pc/f/d/e/m=1, no flush. State updates are inhibited, except that an mdu_done clear still applies.
//   - pc_src_e: flush_d=1, flush_e=1, no stalls. A concurrent lu/sbh stall is dropped.
//   - lu|raw0|sbh|st: stall_pc/f/d=1, flush_e=1 (bubble into E).
//  Scoreboard, registered, updated when not frozen:
//   - set sb_busy[rd_e] on mdu_issue_e with rd_e!=0, and increment outstanding.
//   - clear sb_busy[mdu_done_rd] on mdu_done, and decrement outstanding.
//   - set and clear of the same reg in one cycle: set wins, outstanding unchanged.
//   - a clear is registered, so the D stall releases the cycle after mdu_done; the reader then sees the new RF value.
//   - mdu_done with outstanding==0 (stale op after reset) is ignored: no underflow, no bit change.
//   - outstanding never exceeds MDU_DEPTH. The st stall guarantees this; issuing while full is a protocol error flagged by an assertion.
//  Counters:
//   - stall_cnt +1 each cycle stall_d=1.
//   - flush_cnt +1 each cycle pc_src_e flush fires.
//   - both saturate at all-ones; cnt_clr zeroes them and wins over an increment.
//  Reset mid-operation clears the scoreboard asynchronously. Outputs are valid the same cycle rst_n deasserts.
// STRUCTURE
//  Package hazard_pkg:
//   - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
//   - default RA_W and NUM_REGS.
//  Sub-module hazard_scoreboard: the busy vector, outstanding counter, set/clear/freeze logic.
//  Top level holds the forward muxes, hazard priority and perf counters.
// TESTING
//  1. x1 written in M, rs1_e=1 -> forward_a_e=10.
//     Same reg also in W -> 10. rs2_e=0 with rd_w=0 -> 00.
//  2. lw x5 in E, add rs2_d=5 -> stall_pc/f/d=1 and flush_e=1 for exactly 1 cycle, stall_cnt=1.
//  3. mem_req_m=1, mem_ready low 3 cycles, lu also true -> 3 cycles all stalls=1, no flush.
//     Then 1 lu cycle follows.
//  4. MDU issue rd=7, reader rs1_d=7 -> stalls until cycle after mdu_done(7).
//     mdu_done(7) with issue rd=7 in the same cycle -> sb_busy[7] stays 1.
//  5. MDU_DEPTH=2, two issues, mdu_op_d=1 -> st stall. pc_src_e during lu -> flush_d/e=1, no stall, flush_cnt+1.
//  6. FWD_EN=0: rd_w=3 writing, rs1_d=3 -> D stalls and forwards stay 00.
//     rst_n low mid-MDU -> sb_busy=0, a later stale mdu_done is ignored.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the RV32 hazard controller: forward-select
// encodings, pipeline control bundle and default register-file geometry.
package hazard_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int RA_W_DEF     = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
  } ctl_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for the multi-cycle MUL/DIV unit: one busy bit per
// architectural register plus a count of ops still in flight.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int RA_W      = RA_W_DEF,
  parameter int MDU_DEPTH = 2,
  localparam int OUT_W    = $clog2(MDU_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                freeze,
  input  logic                issue,
  input  logic [RA_W-1:0]     issue_rd,
  input  logic                done,
  input  logic [RA_W-1:0]     done_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic [OUT_W-1:0]    outstanding
);

  logic                issue_eff;
  logic                done_eff;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [OUT_W-1:0]    out_nxt;

  // A frozen E stage holds the op, so it has not issued yet. A completion is
  // a real RF write and is honoured even while frozen; with nothing in
  // flight it can only be a stale op from before reset.
  assign issue_eff = issue & ~freeze;
  assign done_eff  = done & (outstanding != '0);

  // NOTE: every variable gets a full default before any conditional update,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_nxt = busy;
    out_nxt  = outstanding;
    if (done_eff) busy_nxt[done_rd] = 1'b0;
    if (issue_eff && issue_rd != '0) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    if (issue_eff && !done_eff)      out_nxt = outstanding + OUT_W'(1);
    else if (!issue_eff && done_eff) out_nxt = outstanding - OUT_W'(1);
  end

  // NOTE: the busy vector is a handful of flops, not a RAM, so it is reset
  // along with the counter; a stale busy bit would stall D forever.
  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy        <= busy_nxt;
      outstanding <= out_nxt;
    end
  end

  ast_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_eff && !done_eff && outstanding == OUT_W'(MDU_DEPTH)));

endmodule

// File: rtl/hazard_unit_sb.sv
// Five-stage RV32 hazard controller: forwarding selects, stall/flush priority
// (memory freeze > branch flush > data hazards) and saturating perf counters.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int FWD_EN    = 1,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int RA_W      = RA_W_DEF,
  parameter int MDU_DEPTH = 2,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RA_W-1:0]     rs1_d,
  input  logic [RA_W-1:0]     rs2_d,
  input  logic [RA_W-1:0]     rd_d,
  input  logic                reg_write_d,
  input  logic                mdu_op_d,
  input  logic [RA_W-1:0]     rs1_e,
  input  logic [RA_W-1:0]     rs2_e,
  input  logic [RA_W-1:0]     rd_e,
  input  logic                is_load_e,
  input  logic                pc_src_e,
  input  logic                mdu_issue_e,
  input  logic [RA_W-1:0]     rd_m,
  input  logic [RA_W-1:0]     rd_w,
  input  logic                reg_write_m,
  input  logic                reg_write_w,
  input  logic                mem_req_m,
  input  logic                mem_ready,
  input  logic                mdu_done,
  input  logic [RA_W-1:0]     mdu_done_rd,
  input  logic                cnt_clr,
  output logic [1:0]          forward_a_e,
  output logic [1:0]          forward_b_e,
  output logic                stall_pc,
  output logic                stall_f,
  output logic                stall_d,
  output logic                stall_e,
  output logic                stall_m,
  output logic                flush_d,
  output logic                flush_e,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int OUT_W = $clog2(MDU_DEPTH + 1);

  logic [OUT_W-1:0] outstanding;
  fwd_sel_e         fwd_a;
  fwd_sel_e         fwd_b;
  ctl_t             ctl;
  logic             freeze;
  logic             lu;
  logic             raw0;
  logic             sbh;
  logic             st;
  logic             br_flush;

  hazard_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .RA_W      (RA_W),
    .MDU_DEPTH (MDU_DEPTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .freeze      (freeze),
    .issue       (mdu_issue_e),
    .issue_rd    (rd_e),
    .done        (mdu_done),
    .done_rd     (mdu_done_rd),
    .busy        (sb_busy),
    .outstanding (outstanding)
  );

  function automatic fwd_sel_e fwd_pick(input logic [RA_W-1:0] rs,
                                        input logic [RA_W-1:0] rdm, input logic wm,
                                        input logic [RA_W-1:0] rdw, input logic ww);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (FWD_EN != 0 && rs != '0) begin
      if (wm && rs == rdm)      sel = FWD_M;
      else if (ww && rs == rdw) sel = FWD_W;
    end
    return sel;
  endfunction

  // Without forwarding, E carries no write-enable here, so any E destination
  // match is treated as a pending write.
  function automatic logic raw_hit(input logic [RA_W-1:0] rs);
    return (rs != '0) &&
           ((rs == rd_e) || (reg_write_m && rs == rd_m) || (reg_write_w && rs == rd_w));
  endfunction

  assign fwd_a       = fwd_pick(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign fwd_b       = fwd_pick(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign forward_a_e = fwd_a;
  assign forward_b_e = fwd_b;

  assign freeze = mem_req_m & ~mem_ready;
  assign lu     = is_load_e && (rd_e != '0) && ((rs1_d == rd_e) || (rs2_d == rd_e));
  assign raw0   = (FWD_EN == 0) ? (raw_hit(rs1_d) | raw_hit(rs2_d)) : 1'b0;
  assign sbh    = sb_busy[rs1_d] | sb_busy[rs2_d] | (reg_write_d & sb_busy[rd_d]);
  assign st     = mdu_op_d && ((int'(outstanding) + int'(mdu_issue_e)) >= MDU_DEPTH);

  always_comb begin
    ctl = '0;
    if (freeze) begin
      ctl.stall_pc = 1'b1;
      ctl.stall_f  = 1'b1;
      ctl.stall_d  = 1'b1;
      ctl.stall_e  = 1'b1;
      ctl.stall_m  = 1'b1;
    end else if (pc_src_e) begin
      // The stalled D instruction is on the wrong path and gets flushed anyway.
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
    end else if (lu || raw0 || sbh || st) begin
      ctl.stall_pc = 1'b1;
      ctl.stall_f  = 1'b1;
      ctl.stall_d  = 1'b1;
      ctl.flush_e  = 1'b1;
    end
  end

  assign stall_pc = ctl.stall_pc;
  assign stall_f  = ctl.stall_f;
  assign stall_d  = ctl.stall_d;
  assign stall_e  = ctl.stall_e;
  assign stall_m  = ctl.stall_m;
  assign flush_d  = ctl.flush_d;
  assign flush_e  = ctl.flush_e;
  assign br_flush = ~freeze & pc_src_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ctl.stall_d && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_flush && flush_cnt != '1)    flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: a forwarding instance and a no-forward
// instance with 3-bit counters share inputs; a monitor pops expected records.
module tb_hazard_unit_sb;
  import hazard_pkg::*;

  localparam logic [6:0] C_NONE = 7'b00000_00;
  localparam logic [6:0] C_LU   = 7'b11100_01;
  localparam logic [6:0] C_FRZ  = 7'b11111_00;
  localparam logic [6:0] C_BR   = 7'b00000_11;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       reg_write_d, mdu_op_d;
    logic [4:0] rs1_e, rs2_e, rd_e;
    logic       is_load_e, pc_src_e, mdu_issue_e;
    logic [4:0] rd_m, rd_w;
    logic       reg_write_m, reg_write_w, mem_req_m, mem_ready, mdu_done;
    logic [4:0] mdu_done_rd;
    logic       cnt_clr;
  } in_t;

  typedef struct {
    string       name;
    bit          sel0;
    logic [1:0]  fa, fb;
    logic [6:0]  ctl;
    bit          chk_sb;
    logic [31:0] sb;
    bit          chk_cnt;
    logic [31:0] scnt, fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, mdu_done_rd;
  logic reg_write_d, mdu_op_d, is_load_e, pc_src_e, mdu_issue_e;
  logic reg_write_m, reg_write_w, mem_req_m, mem_ready, mdu_done, cnt_clr;

  logic [1:0]  d1_fa, d1_fb, d0_fa, d0_fb;
  logic        d1_spc, d1_sf, d1_sd, d1_se, d1_sm, d1_fd, d1_fe;
  logic        d0_spc, d0_sf, d0_sd, d0_se, d0_sm, d0_fd, d0_fe;
  logic [31:0] d1_sb, d0_sb, d1_scnt, d1_fcnt;
  logic [2:0]  d0_scnt, d0_fcnt;
  logic [6:0]  d1_ctl, d0_ctl;

  assign d1_ctl = {d1_spc, d1_sf, d1_sd, d1_se, d1_sm, d1_fd, d1_fe};
  assign d0_ctl = {d0_spc, d0_sf, d0_sd, d0_se, d0_sm, d0_fd, d0_fe};

  hazard_unit_sb #(.FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .mdu_op_d(mdu_op_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .is_load_e(is_load_e), .pc_src_e(pc_src_e), .mdu_issue_e(mdu_issue_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready), .mdu_done(mdu_done),
    .mdu_done_rd(mdu_done_rd), .cnt_clr(cnt_clr), .forward_a_e(d1_fa), .forward_b_e(d1_fb),
    .stall_pc(d1_spc), .stall_f(d1_sf), .stall_d(d1_sd), .stall_e(d1_se), .stall_m(d1_sm),
    .flush_d(d1_fd), .flush_e(d1_fe), .sb_busy(d1_sb), .stall_cnt(d1_scnt), .flush_cnt(d1_fcnt)
  );

  hazard_unit_sb #(.FWD_EN(0), .CNT_W(3)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .mdu_op_d(mdu_op_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .is_load_e(is_load_e), .pc_src_e(pc_src_e), .mdu_issue_e(mdu_issue_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready), .mdu_done(mdu_done),
    .mdu_done_rd(mdu_done_rd), .cnt_clr(cnt_clr), .forward_a_e(d0_fa), .forward_b_e(d0_fb),
    .stall_pc(d0_spc), .stall_f(d0_sf), .stall_d(d0_sd), .stall_e(d0_se), .stall_m(d0_sm),
    .flush_d(d0_fd), .flush_e(d0_fe), .sb_busy(d0_sb), .stall_cnt(d0_scnt), .flush_cnt(d0_fcnt)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: outputs are combinational, so every record queued this cycle is
  // compared on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.sel0) begin
        check({cur.name, "/fwd0"}, {d0_fa, d0_fb}, {cur.fa, cur.fb});
        check({cur.name, "/ctl0"}, d0_ctl, cur.ctl);
        if (cur.chk_sb)  check({cur.name, "/sb0"}, d0_sb, cur.sb);
        if (cur.chk_cnt) check({cur.name, "/cnt0"}, {d0_scnt, d0_fcnt}, {cur.scnt[2:0], cur.fcnt[2:0]});
      end else begin
        check({cur.name, "/fwd"}, {d1_fa, d1_fb}, {cur.fa, cur.fb});
        check({cur.name, "/ctl"}, d1_ctl, cur.ctl);
        if (cur.chk_sb)  check({cur.name, "/sb"}, d1_sb, cur.sb);
        if (cur.chk_cnt) check({cur.name, "/cnt"}, {d1_scnt, d1_fcnt}, {cur.scnt, cur.fcnt});
      end
    end
  end

  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    v.rst_n     = 1'b1;
    v.mem_ready = 1'b1;
    return v;
  endfunction

  function automatic exp_t ex(string name, logic [1:0] fa, logic [1:0] fb, logic [6:0] ctl);
    exp_t e;
    e = '{name: name, sel0: 1'b0, fa: fa, fb: fb, ctl: ctl, chk_sb: 1'b0, sb: '0,
          chk_cnt: 1'b0, scnt: '0, fcnt: '0};
    return e;
  endfunction

  function automatic exp_t w_sb(exp_t e, logic [31:0] sb);
    e.chk_sb = 1'b1; e.sb = sb; return e;
  endfunction

  function automatic exp_t w_cnt(exp_t e, logic [31:0] s, logic [31:0] f);
    e.chk_cnt = 1'b1; e.scnt = s; e.fcnt = f; return e;
  endfunction

  function automatic exp_t nofwd(exp_t e);
    e.sel0 = 1'b1; return e;
  endfunction

  task automatic apply(input in_t v);
    rst_n = v.rst_n; rs1_d = v.rs1_d; rs2_d = v.rs2_d; rd_d = v.rd_d;
    reg_write_d = v.reg_write_d; mdu_op_d = v.mdu_op_d;
    rs1_e = v.rs1_e; rs2_e = v.rs2_e; rd_e = v.rd_e;
    is_load_e = v.is_load_e; pc_src_e = v.pc_src_e; mdu_issue_e = v.mdu_issue_e;
    rd_m = v.rd_m; rd_w = v.rd_w; reg_write_m = v.reg_write_m; reg_write_w = v.reg_write_w;
    mem_req_m = v.mem_req_m; mem_ready = v.mem_ready; mdu_done = v.mdu_done;
    mdu_done_rd = v.mdu_done_rd; cnt_clr = v.cnt_clr;
  endtask

  task automatic vec(input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    apply(v);
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    in_t v;
    v = idle(); v.rst_n = 1'b0;
    apply(v);
    repeat (3) @(posedge clk);

    // reset state, outputs valid the cycle reset releases
    v = idle();                                                          vec(v, w_cnt(w_sb(ex("reset", 2'b00, 2'b00, C_NONE), 0), 0, 0));
    // forwarding
    v = idle(); v.rs1_e = 1; v.rd_m = 1; v.reg_write_m = 1;              vec(v, ex("fwd_m", 2'b10, 2'b00, C_NONE));
    v.rd_w = 1; v.reg_write_w = 1;                                       vec(v, ex("fwd_m_over_w", 2'b10, 2'b00, C_NONE));
    v = idle(); v.rs1_e = 4; v.rd_w = 4; v.reg_write_w = 1; v.reg_write_m = 1;
                                                                         vec(v, ex("fwd_w_x0", 2'b01, 2'b00, C_NONE));
    v = idle(); v.rs2_e = 6; v.rd_m = 6; v.rd_w = 6; v.reg_write_w = 1;  vec(v, ex("fwd_m_disabled", 2'b00, 2'b01, C_NONE));
    // load-use
    v = idle(); v.is_load_e = 1; v.rd_e = 5; v.rs2_d = 5;                vec(v, ex("lu", 2'b00, 2'b00, C_LU));
    v = idle();                                                          vec(v, w_cnt(ex("lu_release", 2'b00, 2'b00, C_NONE), 1, 0));
    // freeze over load-use for 3 cycles, then the load-use bubble
    v = idle(); v.mem_req_m = 1; v.mem_ready = 0; v.is_load_e = 1; v.rd_e = 5; v.rs1_d = 5;
    for (int i = 0; i < 3; i++)                                          vec(v, ex("freeze", 2'b00, 2'b00, C_FRZ));
    v.mem_ready = 1;                                                     vec(v, ex("freeze_then_lu", 2'b00, 2'b00, C_LU));
    v = idle();                                                          vec(v, w_cnt(ex("after_freeze", 2'b00, 2'b00, C_NONE), 5, 0));
    // MDU scoreboard stall and release
    v = idle(); v.mdu_issue_e = 1; v.rd_e = 7;                           vec(v, w_sb(ex("mdu_issue7", 2'b00, 2'b00, C_NONE), 0));
    v = idle(); v.rs1_d = 7;                                             vec(v, w_sb(ex("sb_stall", 2'b00, 2'b00, C_LU), 32'h80));
    v.mdu_done = 1; v.mdu_done_rd = 7;                                   vec(v, ex("sb_stall_done", 2'b00, 2'b00, C_LU));
    v = idle(); v.rs1_d = 7;                                             vec(v, w_cnt(w_sb(ex("sb_release", 2'b00, 2'b00, C_NONE), 0), 7, 0));
    // set and clear of the same register in one cycle
    v = idle(); v.mdu_issue_e = 1; v.rd_e = 7;                           vec(v, ex("issue7_again", 2'b00, 2'b00, C_NONE));
    v.mdu_done = 1; v.mdu_done_rd = 7;                                   vec(v, w_sb(ex("set_clr_same", 2'b00, 2'b00, C_NONE), 32'h80));
    v = idle();                                                          vec(v, w_sb(ex("set_wins", 2'b00, 2'b00, C_NONE), 32'h80));
    v = idle(); v.mdu_done = 1; v.mdu_done_rd = 7;                       vec(v, ex("drain7", 2'b00, 2'b00, C_NONE));
    // MDU structural stall at depth 2
    v = idle(); v.mdu_issue_e = 1; v.rd_e = 8;                           vec(v, w_sb(ex("issue8", 2'b00, 2'b00, C_NONE), 0));
    v.rd_e = 9; v.mdu_op_d = 1; v.rd_d = 10; v.reg_write_d = 1;          vec(v, w_sb(ex("st_issue9", 2'b00, 2'b00, C_LU), 32'h100));
    v = idle(); v.mdu_op_d = 1;                                          vec(v, w_sb(ex("st_full", 2'b00, 2'b00, C_LU), 32'h300));
    v.mdu_done = 1; v.mdu_done_rd = 8;                                   vec(v, ex("st_done8", 2'b00, 2'b00, C_LU));
    v = idle(); v.mdu_op_d = 1;                                          vec(v, w_cnt(w_sb(ex("st_release", 2'b00, 2'b00, C_NONE), 32'h200), 10, 0));
    v = idle(); v.mdu_done = 1; v.mdu_done_rd = 9;                       vec(v, ex("drain9", 2'b00, 2'b00, C_NONE));
    // branch flush beats load-use
    v = idle(); v.pc_src_e = 1; v.is_load_e = 1; v.rd_e = 5; v.rs1_d = 5; vec(v, ex("br_over_lu", 2'b00, 2'b00, C_BR));
    v = idle();                                                          vec(v, w_cnt(ex("after_br", 2'b00, 2'b00, C_NONE), 10, 1));
    // WAW hazard needs reg_write_d
    v = idle(); v.mdu_issue_e = 1; v.rd_e = 11;                          vec(v, ex("issue11", 2'b00, 2'b00, C_NONE));
    v = idle(); v.rd_d = 11; v.reg_write_d = 1;                          vec(v, ex("waw", 2'b00, 2'b00, C_LU));
    v.reg_write_d = 0;                                                   vec(v, ex("waw_no_write", 2'b00, 2'b00, C_NONE));
    v = idle(); v.mdu_done = 1; v.mdu_done_rd = 11;                      vec(v, w_cnt(ex("drain11", 2'b00, 2'b00, C_NONE), 11, 1));
    // freeze blocks an issue but still honours a completion
    v = idle(); v.mem_req_m = 1; v.mem_ready = 0; v.mdu_issue_e = 1; v.rd_e = 12;
                                                                         vec(v, ex("frz_issue", 2'b00, 2'b00, C_FRZ));
    v.mem_ready = 1;                                                     vec(v, w_sb(ex("frz_issue_held", 2'b00, 2'b00, C_NONE), 0));
    v = idle(); v.mem_req_m = 1; v.mem_ready = 0; v.mdu_done = 1; v.mdu_done_rd = 12;
                                                                         vec(v, w_sb(ex("frz_done", 2'b00, 2'b00, C_FRZ), 32'h1000));
    v = idle();                                                          vec(v, w_cnt(w_sb(ex("frz_done_clr", 2'b00, 2'b00, C_NONE), 0), 13, 1));
    // no-forward instance: RAW on W stalls; small counters are saturated
    v = idle(); v.rd_w = 3; v.reg_write_w = 1; v.rs1_d = 3; v.rs1_e = 3;
    vec(v, w_cnt(nofwd(ex("raw0_w", 2'b00, 2'b00, C_LU)), 7, 1));
    exp_q.push_back(w_cnt(ex("raw0_w_fwd", 2'b01, 2'b00, C_NONE), 13, 1));
    v = idle(); v.rs2_d = 4; v.rd_m = 4;                                 vec(v, nofwd(ex("raw0_m_nowrite", 2'b00, 2'b00, C_NONE)));
    v.reg_write_m = 1;                                                   vec(v, nofwd(ex("raw0_m", 2'b00, 2'b00, C_LU)));
    v = idle(); v.reg_write_w = 1; v.reg_write_m = 1;                    vec(v, nofwd(ex("raw0_x0", 2'b00, 2'b00, C_NONE)));
    // counter clear wins over a same-cycle increment
    v = idle(); v.cnt_clr = 1; v.is_load_e = 1; v.rd_e = 5; v.rs1_d = 5;
    vec(v, ex("clr_lu", 2'b00, 2'b00, C_LU));
    exp_q.push_back(nofwd(ex("clr_lu0", 2'b00, 2'b00, C_LU)));
    v = idle();
    vec(v, w_cnt(ex("cleared", 2'b00, 2'b00, C_NONE), 0, 0));
    exp_q.push_back(w_cnt(nofwd(ex("cleared0", 2'b00, 2'b00, C_NONE)), 0, 0));
    v = idle(); v.is_load_e = 1; v.rd_e = 5; v.rs1_d = 5;                vec(v, ex("lu_after_clr", 2'b00, 2'b00, C_LU));
    v = idle();
    vec(v, w_cnt(ex("count_after_clr", 2'b00, 2'b00, C_NONE), 1, 0));
    exp_q.push_back(w_cnt(nofwd(ex("count_after_clr0", 2'b00, 2'b00, C_NONE)), 1, 0));
    // async reset mid-MDU, then a stale completion
    v = idle(); v.mdu_issue_e = 1; v.rd_e = 13;                          vec(v, ex("issue13", 2'b00, 2'b00, C_NONE));
    v = idle();                                                          vec(v, w_sb(ex("busy13", 2'b00, 2'b00, C_NONE), 32'h2000));
    v = idle(); v.rst_n = 0;                                             vec(v, w_cnt(w_sb(ex("async_rst", 2'b00, 2'b00, C_NONE), 0), 0, 0));
    v = idle(); v.mdu_done = 1; v.mdu_done_rd = 13;                      vec(v, w_sb(ex("stale_done", 2'b00, 2'b00, C_NONE), 0));
    v = idle(); v.mdu_op_d = 1;                                          vec(v, w_sb(ex("no_underflow", 2'b00, 2'b00, C_NONE), 0));
    v = idle();                                                          vec(v, w_sb(ex("final_idle", 2'b00, 2'b00, C_NONE), 0));

    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
